lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store controller between the CPU execute stage and the single-port word memory. It accepts one load or store request at a time and drives the memory's registered read/write port. Loads return sign- or zero-extended bytes and halfwords. Sub-word stores are performed as read-modify-write, because the memory has no byte enables.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width of the request and memory address.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  store data; valid data in the low bits
- `resp_valid`  out  1  one-cycle completion pulse; there is no back-pressure
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `resp_err`  out  1  illegal funct3, or misaligned access (see Configuration); qualified by `resp_valid`
- `mem_addr`  out  ADDR_W  word-aligned byte address, low 2 bits always 0
- `mem_r_enable`  out  1  memory read strobe; data returned on `mem_rdata` the following cycle
- `mem_w_enable`  out  1  memory write strobe; full 32-bit word written
- `mem_wdata`  out  32  write word
- `mem_rdata`  in  32  registered memory read data

## Operation
- FSM states: IDLE, RD, WAIT, WR, RESP.
- IDLE: `req_ready`=1. On accept, latch `we`, `funct3`, `addr` and `wdata`, then branch:
  - Illegal funct3 (011, 110, 111, or a store with funct3[2]=1) → RESP with err=1. No memory access.
  - Load, or sub-word store → RD.
  - SW → WR, with `mem_wdata`=`wdata`.
- RD: `mem_r_enable`=1 and `mem_addr`={addr[ADDR_W-1:2],2'b00}. Go to WAIT.
- WAIT: `mem_rdata` is valid here. Select byte offset addr[1:0] (halfword offset addr[1]).
  - Load: register the extended result, then RESP.
    - B/H: sign-extend.
    - BU/HU: zero-extend.
    - W: pass through.
  - Store: merge into the read word, then WR.
    - SB: replace byte lane addr[1:0] with wdata[7:0].
    - SH: replace lane pair addr[1] with wdata[15:0].
- WR: `mem_w_enable`=1, with `mem_addr` aligned as in RD. Go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- `mem_r_enable` and `mem_w_enable` are never high in the same cycle. Both are 0 outside RD and WR.
- `mem_addr` and `mem_wdata` are don't-care when both strobes are low; they are driven 0 in IDLE.
- `req_valid` while busy is ignored and does not change state.
- Reset, including mid-operation: state=IDLE and every output is 0 except `req_ready`=1. An in-flight write strobe is dropped and the request is lost.

## Timing
Cycles are counted from the accept edge E0.

| Access | Memory strobe | `resp_valid` |
|---|---|---|
| Load | `mem_r_enable` in the cycle after E0 | cycle E0+3 |
| SW | `mem_w_enable` in the cycle after E0 | cycle E0+2 |
| SB/SH | read cycle E0+1, write cycle E0+3 | cycle E0+4 |
| Error | none | cycle E0+1 |

- `req_ready` rises in the cycle after `resp_valid`. The minimum spacing between accepted loads is 4 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `mem_*`.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined: a misaligned access produces `resp_err`=1 via the error path in cycle E0+1, with no memory access.
  - Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]≠0.
- Undefined: low address bits below the access size are ignored.
  - Halfword uses addr[1] only.
  - Word uses aligned addr.
  - `resp_err` is raised only for an illegal funct3.

## Test plan
Preload word 0x190 = 0x04030201 and word 0x19C = 0xFF0F0E0D.

- LW 0x190 → `resp_valid` at E0+3, `resp_rdata`=0x04030201, err=0. Exactly one `mem_r_enable` pulse, with `mem_addr`=0x190.
- LB 0x19F → 0xFFFFFFFF. LBU 0x19F → 0x000000FF. LH 0x19E → 0xFFFFFF0F. LHU 0x19C → 0x00000E0D.
- SB 0xAB to 0x191, then LW 0x190 → 0x0403AB01. SH 0xBEEF to 0x192, then LW 0x190 → 0xBEEFAB01. Check the store response arrives at E0+4.
- SW 0xDEADBEEF to 0x190 → single `mem_w_enable` in cycle E0+1, response at E0+2. A following LW returns 0xDEADBEEF.
- Error cases:
  - funct3=011 load → response at E0+1 with err=1 and no memory strobes.
  - With `LSU_MISALIGN_TRAP_EN`: LW 0x191 → err=1.
  - Without it: LW 0x191 returns the word at 0x190.
- Assert `rst` in the RD cycle of an SB → all outputs 0 and `req_ready`=1 immediately, memory unchanged. A new LW after release completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time, sub-word stores via read-modify-write.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_r_enable,
    output logic              mem_w_enable,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic        illegal;
    logic        misalign;
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;

    assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                     || (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                      || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = illegal || misalign;
                    if (illegal || misalign) begin
                        state_d = StResp;
                    end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StWait;
            StWait: begin
                if (!we_q) begin
                    unique case (funct3_q[1:0])
                        2'b00:   rdata_d = funct3_q[2] ? {24'h0, byte_sel}
                                                       : {{24{byte_sel[7]}}, byte_sel};
                        2'b01:   rdata_d = funct3_q[2] ? {16'h0, half_sel}
                                                       : {{16{half_sel[15]}}, half_sel};
                        default: rdata_d = mem_rdata;
                    endcase
                    state_d = StResp;
                end else begin
                    // Merged word replaces the store data for the write cycle.
                    wdata_d = merged;
                    state_d = StWr;
                end
            end
            StWr:   state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign req_ready    = (state_q == StIdle);
    assign mem_r_enable = (state_q == StRd);
    assign mem_w_enable = (state_q == StWr);
    assign mem_addr     = (mem_r_enable || mem_w_enable) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata    = mem_w_enable ? wdata_q : 32'h0;
    assign resp_valid   = (state_q == StResp);
    assign resp_rdata   = resp_valid ? rdata_q : 32'h0;
    assign resp_err     = resp_valid && err_q;

endmodule
